mdu_iterative: RTL and testbench

- Multicycle multiply/divide unit for the EX stage of the five-stage MIPS pipeline.
- Takes forwarded EX operands and a start pulse from the EX control, iterates for 32 cycles, then delivers a 64-bit {hi,lo} result to the HILO write path.
- Drives busy, which the hazard unit uses to stall IF/ID/EX.
- Supports MULT, MULTU, DIV and DIVU using a radix-2 shift-add multiply and a restoring divide.

---
 rtl/mdu_iterative_pkg.sv | 22 ++
 rtl/mdu_iter_step.sv | 31 +++
 rtl/mdu_iterative.sv | 159 +++++++++++++++
 tb/tb_mdu_iterative.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iterative_pkg.sv
// Shared constants for the iterative multiply/divide unit: operand width,
// operation encodings, FSM state encodings and a sign-correction helper.
package mdu_iterative_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCalc  = 2'd1;
  localparam logic [1:0] StFixup = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Two's-complement negate when neg is set; used for magnitudes and fixup.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: MSB-first shift-add multiply step, or one
// restoring-divide step producing a single quotient bit.
module mdu_iter_step
  import mdu_iterative_pkg::*;
(
  input  logic              div_mode_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  input  logic              bit_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              q_bit_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    shifted = {acc_i[XLEN-1:0], bit_i};
    diff    = {1'b0, shifted} - {2'b00, operand_i};
    acc_o   = '0;
    q_bit_o = 1'b0;
    if (div_mode_i) begin
      // Partial remainder lives in the low XLEN+1 bits; a borrow means restore.
      q_bit_o          = ~diff[XLEN+1];
      acc_o[XLEN:0]    = q_bit_o ? diff[XLEN:0] : shifted;
    end else begin
      acc_o = (acc_i << 1) + (bit_i ? {{XLEN{1'b0}}, operand_i} : {(2*XLEN){1'b0}});
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Multicycle MULT/MULTU/DIV/DIVU unit: magnitude iteration over ITER cycles,
// then sign fixup into the {hi,lo} result register with a one-cycle ready.
module mdu_iterative
  import mdu_iterative_pkg::*;
#(
  parameter int unsigned ITER = XLEN
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   src_a_i,
  input  logic [XLEN-1:0]   src_b_i,
  input  logic              cancel_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic [2*XLEN-1:0] result_o
);

  localparam int unsigned     CntW    = $clog2(ITER);
  localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);

  logic [1:0]        state_q, state_d;
  logic              is_div_q, is_div_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  // Shifts multiplier/dividend bits out at the top, quotient bits in at the bottom.
  logic [XLEN-1:0]   sh_q, sh_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              divz_q, divz_d;
  logic [XLEN-1:0]   src_a_q, src_a_d;
  logic [2*XLEN-1:0] result_q, result_d;

  logic              accept;
  logic              is_signed, sign_a, sign_b;
  logic [2*XLEN-1:0] step_acc;
  logic              step_q;
  logic [2*XLEN-1:0] fixed;
  logic [XLEN-1:0]   quo, rem;

  mdu_iter_step u_step (
    .div_mode_i (is_div_q),
    .acc_i      (acc_q),
    .operand_i  (opnd_q),
    .bit_i      (sh_q[XLEN-1]),
    .acc_o      (step_acc),
    .q_bit_o    (step_q)
  );

  always_comb begin
    quo = cond_neg(sh_q, neg_lo_q);
    rem = cond_neg(acc_q[XLEN-1:0], neg_hi_q);
    if (!is_div_q) begin
      fixed = neg_lo_q ? -acc_q : acc_q;
    end else if (divz_q) begin
      fixed = {src_a_q, {XLEN{1'b1}}};
    end else begin
      fixed = {rem, quo};
    end
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    opnd_d    = opnd_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    divz_d    = divz_q;
    src_a_d   = src_a_q;
    result_d  = result_q;

    accept    = start_i & ~cancel_i & ((state_q == StIdle) | (state_q == StDone));
    is_signed = ~op_i[0];
    sign_a    = is_signed & src_a_i[XLEN-1];
    sign_b    = is_signed & src_b_i[XLEN-1];

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          state_d  = StCalc;
          is_div_d = op_i[1];
          acc_d    = '0;
          cnt_d    = '0;
          src_a_d  = src_a_i;
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = op_i[1] ? sign_a : (sign_a ^ sign_b);
          divz_d   = op_i[1] & (src_b_i == '0);
          if (op_i[1]) begin
            opnd_d = cond_neg(src_b_i, sign_b);
            sh_d   = cond_neg(src_a_i, sign_a);
          end else begin
            opnd_d = cond_neg(src_a_i, sign_a);
            sh_d   = cond_neg(src_b_i, sign_b);
          end
        end
      end
      StCalc: begin
        if (cancel_i) begin
          state_d = StIdle;
        end else begin
          acc_d = step_acc;
          sh_d  = {sh_q[XLEN-2:0], step_q};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StFixup;
          end
        end
      end
      StFixup: begin
        if (cancel_i) begin
          state_d = StIdle;
        end else begin
          result_d = fixed;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      sh_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      divz_q   <= 1'b0;
      src_a_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      divz_q   <= divz_d;
      src_a_q  <= src_a_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == StCalc) | (state_q == StFixup);
  assign ready_o  = (state_q == StDone);
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed vector table, multi-cycle
// corner sequences and random operations against an arithmetic model.
module tb_mdu_iterative;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        cancel_i;
  logic        busy_o;
  logic        ready_o;
  logic [63:0] result_o;

  int errors = 0;
  int checks = 0;

  mdu_iterative dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .op_i     (op_i),
    .src_a_i  (src_a_i),
    .src_b_i  (src_b_i),
    .cancel_i (cancel_i),
    .busy_o   (busy_o),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain MIPS arithmetic, with the divide-by-zero and overflow rules.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              q, r;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        return up;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Entered just after a negedge; observes 40 negedges after the start edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int cancel_at,
                        output int rdy_cyc, output int rdy_cnt, output int busy_cnt);
    rdy_cyc  = 0;
    rdy_cnt  = 0;
    busy_cnt = 0;
    start_i  = 1'b1;
    op_i     = op;
    src_a_i  = a;
    src_b_i  = b;
    @(posedge clk_i);
    #1;
    if (hold > 0) begin
      op_i    = ~op;
      src_a_i = a ^ 32'h5A5A0F0F;
      src_b_i = b + 32'd3;
    end else begin
      start_i = 1'b0;
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      if (busy_o) busy_cnt++;
      if (ready_o) begin
        rdy_cnt++;
        if (rdy_cyc == 0) rdy_cyc = i;
      end
      if (i == hold) start_i = 1'b0;
      cancel_i = (i == cancel_at);
    end
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      if (ready_o) begin
        cyc = i;
        break;
      end
    end
  endtask

  int          lat, pulses, bcnt;
  logic [1:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    cancel_i = 1'b0;
    op_i     = 2'b00;
    src_a_i  = '0;
    src_b_i  = '0;

    vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD};
    vecs[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
    vecs[4] = '{2'b11, 32'd1234,     32'd0,        64'h000004D2_FFFFFFFF};
    vecs[5] = '{2'b11, 32'd9,        32'd3,        64'h00000000_00000003};
    vecs[6] = '{2'b10, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[8] = '{2'b10, 32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_FFFFFFFF};
    vecs[9] = '{2'b01, 32'd0,        32'd12345,    64'h0};

    repeat (2) @(negedge clk_i);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    foreach (vecs[k]) begin
      run_op(vecs[k].op, vecs[k].a, vecs[k].b, 0, 0, lat, pulses, bcnt);
      check($sformatf("vec%0d_result", k), result_o, vecs[k].exp);
      check($sformatf("vec%0d_latency", k), 64'(lat), 64'd34);
      check($sformatf("vec%0d_pulses", k), 64'(pulses), 64'd1);
      check($sformatf("vec%0d_busy", k), 64'(bcnt), 64'd33);
    end

    // start held with other operands during CALC must be ignored
    run_op(2'b00, 32'd6, 32'd7, 30, 0, lat, pulses, bcnt);
    check("hold_result", result_o, 64'd42);
    check("hold_latency", 64'(lat), 64'd34);
    check("hold_pulses", 64'(pulses), 64'd1);

    // cancel at CALC cycle 10
    run_op(2'b00, 32'd11, 32'd13, 0, 10, lat, pulses, bcnt);
    check("cancel_result", result_o, 64'd42);
    check("cancel_pulses", 64'(pulses), 64'd0);
    check("cancel_busy", 64'(bcnt), 64'd10);

    // cancel in IDLE suppresses start
    start_i  = 1'b1;
    cancel_i = 1'b1;
    op_i     = 2'b01;
    src_a_i  = 32'd3;
    src_b_i  = 32'd3;
    @(posedge clk_i);
    #1;
    start_i  = 1'b0;
    cancel_i = 1'b0;
    check("idle_cancel_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);

    // back-to-back: DIVU accepted in the DONE cycle of a MULTU
    start_i = 1'b1;
    op_i    = 2'b01;
    src_a_i = 32'hFFFFFFFF;
    src_b_i = 32'hFFFFFFFF;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_ready(lat);
    check("b2b_first_latency", 64'(lat), 64'd34);
    check("b2b_first_result", result_o, 64'hFFFFFFFE_00000001);
    start_i = 1'b1;
    op_i    = 2'b11;
    src_a_i = 32'd100;
    src_b_i = 32'd7;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    check("b2b_accept_busy", 64'(busy_o), 64'd1);
    check("b2b_accept_ready", 64'(ready_o), 64'd0);
    wait_ready(lat);
    check("b2b_second_latency", 64'(lat), 64'd34);
    check("b2b_second_result", result_o, {32'd2, 32'd14});
    @(negedge clk_i);

    for (int n = 0; n < 30; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 0, 0, lat, pulses, bcnt);
      check($sformatf("rand%0d_op%0d_%h_%h", n, rop, ra, rb), result_o, model(rop, ra, rb));
      check($sformatf("rand%0d_latency", n), 64'(lat), 64'd34);
    end

    // asynchronous reset at CALC cycle 20
    start_i = 1'b1;
    op_i    = 2'b00;
    src_a_i = 32'd123;
    src_b_i = 32'd456;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (20) @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy_o), 64'd0);
    check("async_rst_ready", 64'(ready_o), 64'd0);
    check("async_rst_result", result_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_op(2'b11, 32'd9, 32'd3, 0, 0, lat, pulses, bcnt);
    check("post_rst_result", result_o, 64'd3);
    check("post_rst_latency", 64'(lat), 64'd34);
    check("post_rst_pulses", 64'(pulses), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
